ps2_scan_rx: RTL

PS/2 keyboard receiver that sits directly upstream of the memory-mapped I/O block and feeds its 32-bit keyboard word (`keyb_char`), which also drives the 8-digit display. It samples the raw `ps2_clk`/`ps2_data` pins on the 100 MHz domain and deglitches them. It deserialises 11-bit frames, checks framing and parity, and folds `E0`/`F0` prefixes into a single decoded key event. The CPU polls `keyb_char`; no interrupt is used.

---
 rtl/ps2_scan_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver. Synchronises and deglitches the pins, deserialises 11-bit frames,
// and folds E0/F0 prefixes into one key event word for the memory-mapped I/O block.
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keyb_char,
    output logic        key_valid,
    output logic        frame_err
);

    localparam int FC_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [FC_W-1:0] FC_MAX  = {FC_W{1'b1}};
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    function automatic logic [FC_W-1:0] sat_inc(input logic [FC_W-1:0] v);
        return (v == FC_MAX) ? v : v + 1'b1;
    endfunction

    logic clk_p0, clk_p1, dat_p0, dat_p1;
    logic filt_p2, fall_p2, dat_p2;
    logic [FC_W-1:0] fcnt_p2;

    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      sh;
    logic            par;
    logic [WD_W-1:0] wd;
    logic            ext_p, brk_p;

    // Stage p0/p1: two-flop synchroniser, idle-high line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_data;
            dat_p1 <= dat_p0;
        end
    end

    // Stage p2: clock filter; level flips after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_p2 <= 1'b1;
            fcnt_p2 <= '0;
            fall_p2 <= 1'b0;
            dat_p2  <= 1'b1;
        end else begin
            fall_p2 <= 1'b0;
            dat_p2  <= dat_p1;
            if (clk_p1 == filt_p2) begin
                fcnt_p2 <= '0;
            end else if (fcnt_p2 == FC_LAST) begin
                filt_p2 <= clk_p1;
                fcnt_p2 <= '0;
                fall_p2 <= filt_p2;
            end else begin
                fcnt_p2 <= sat_inc(fcnt_p2);
            end
        end
    end

    // Frame FSM, watchdog and prefix decoder
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            par       <= 1'b0;
            wd        <= '0;
            ext_p     <= 1'b0;
            brk_p     <= 1'b0;
            keyb_char <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;

            if (fall_p2 || state == IDLE) wd <= '0;
            else                          wd <= wd + 1'b1;

            if (fall_p2) begin
                case (state)
                    IDLE: begin
                        if (!dat_p2) begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        sh      <= {dat_p2, sh[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_p2;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (dat_p2 && (^{sh, par})) begin
                            if (sh == 8'hE0) begin
                                ext_p <= 1'b1;
                            end else if (sh == 8'hF0) begin
                                brk_p <= 1'b1;
                            end else begin
                                keyb_char <= {22'b0, brk_p, ext_p, sh};
                                key_valid <= 1'b1;
                                ext_p     <= 1'b0;
                                brk_p     <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext_p     <= 1'b0;
                            brk_p     <= 1'b0;
                        end
                    end
                endcase
            end else if (state != IDLE && wd == WD_LAST) begin
                // Stalled frame: drop the partial byte and any pending prefix
                state     <= IDLE;
                frame_err <= 1'b1;
                ext_p     <= 1'b0;
                brk_p     <= 1'b0;
            end
        end
    end

endmodule
